wsa_acc: RTL and testbench

Downstream consumer of the three-output bitwise stage (OR / AND / XOR streams). It joins the three 32-bit result streams beat by beat and checks the identity `or == and ^ xor` with `and & xor == 0` on each joined beat. It accumulates a wrapping sum of the OR values and a mismatch count over a window of COUNT beats, then emits both totals on two independently handshaked output channels.

---
 rtl/wsa_acc.sv | 188 ++++++++++++++++++
 tb/tb_wsa_acc.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wsa_acc.sv
// wsa_acc: joins OR/AND/XOR beats, flags beats where or != and^xor or and&xor != 0, totals per COUNT-beat window.
// Latency: totals are valid one cycle after the window's last beat is consumed; one beat per cycle while accumulating.
// Backpressure: one register per input stream; a full stream stalls while the join is blocked or totals are pending.
module wsa_acc #(
  parameter int COUNT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wsa_acc__in0,
  input  logic        wsa_acc__in0_vld,
  output logic        wsa_acc__in0_rdy,
  input  logic [31:0] wsa_acc__in1,
  input  logic        wsa_acc__in1_vld,
  output logic        wsa_acc__in1_rdy,
  input  logic [31:0] wsa_acc__in2,
  input  logic        wsa_acc__in2_vld,
  output logic        wsa_acc__in2_rdy,
  output logic [31:0] wsa_acc__out0,
  output logic        wsa_acc__out0_vld,
  input  logic        wsa_acc__out0_rdy,
  output logic [31:0] wsa_acc__out1,
  output logic        wsa_acc__out1_vld,
  input  logic        wsa_acc__out1_rdy
);

  typedef enum logic {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } state_t;

  localparam logic [15:0] LAST_BEAT = 16'(COUNT - 1);

  state_t      state;
  state_t      state_nxt;

  logic [31:0] in0_reg;
  logic [31:0] in1_reg;
  logic [31:0] in2_reg;
  logic        in0_vreg;
  logic        in1_vreg;
  logic        in2_vreg;
  logic        in0_load;
  logic        in1_load;
  logic        in2_load;

  logic        consume;
  logic        close_window;
  logic        last_beat;
  logic        mismatch;
  logic        out0_take;
  logic        out1_take;

  logic [31:0] sum_reg;
  logic [31:0] sum_nxt;
  logic [15:0] err_reg;
  logic [15:0] err_nxt;
  logic [15:0] beat_cnt;

  // Input stage: a stream register refills when empty or when it drains this cycle.
  assign in0_load = consume | ~in0_vreg;
  assign in1_load = consume | ~in1_vreg;
  assign in2_load = consume | ~in2_vreg;

  // rst masks rdy so no upstream beat appears accepted while reset is held.
  assign wsa_acc__in0_rdy = wsa_acc__in0_vld & in0_load & ~rst;
  assign wsa_acc__in1_rdy = wsa_acc__in1_vld & in1_load & ~rst;
  assign wsa_acc__in2_rdy = wsa_acc__in2_vld & in2_load & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      in0_reg  <= 32'd0;
      in1_reg  <= 32'd0;
      in2_reg  <= 32'd0;
      in0_vreg <= 1'b0;
      in1_vreg <= 1'b0;
      in2_vreg <= 1'b0;
    end else begin
      if (in0_load) begin
        in0_vreg <= wsa_acc__in0_vld;
        in0_reg  <= wsa_acc__in0;
      end
      if (in1_load) begin
        in1_vreg <= wsa_acc__in1_vld;
        in1_reg  <= wsa_acc__in1;
      end
      if (in2_load) begin
        in2_vreg <= wsa_acc__in2_vld;
        in2_reg  <= wsa_acc__in2;
      end
    end
  end

  assign mismatch  = (|(in1_reg & in2_reg)) | ((in1_reg | in2_reg) != in0_reg);
  assign sum_nxt   = sum_reg + in0_reg;
  assign err_nxt   = err_reg + {15'd0, mismatch};
  assign last_beat = (beat_cnt == LAST_BEAT);
  assign out0_take = wsa_acc__out0_vld & wsa_acc__out0_rdy;
  assign out1_take = wsa_acc__out1_vld & wsa_acc__out1_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM: begin
        if (close_window) begin
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        // Leave once no output stays pending past this edge.
        if (!(wsa_acc__out0_vld && !wsa_acc__out0_rdy) &&
            !(wsa_acc__out1_vld && !wsa_acc__out1_rdy)) begin
          state_nxt = ACCUM;
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_comb begin
    consume      = 1'b0;
    close_window = 1'b0;
    case (state)
      ACCUM: begin
        consume      = in0_vreg & in1_vreg & in2_vreg;
        close_window = in0_vreg & in1_vreg & in2_vreg & last_beat;
      end
      default: begin
        consume      = 1'b0;
        close_window = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_reg  <= 32'd0;
      err_reg  <= 16'd0;
      beat_cnt <= 16'd0;
    end else if (consume) begin
      if (last_beat) begin
        sum_reg  <= 32'd0;
        err_reg  <= 16'd0;
        beat_cnt <= 16'd0;
      end else begin
        sum_reg  <= sum_nxt;
        err_reg  <= err_nxt;
        beat_cnt <= beat_cnt + 16'd1;
      end
    end
  end

  // Output data only changes when a window closes, so it is stable while vld is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      wsa_acc__out0     <= 32'd0;
      wsa_acc__out1     <= 32'd0;
      wsa_acc__out0_vld <= 1'b0;
      wsa_acc__out1_vld <= 1'b0;
    end else if (close_window) begin
      wsa_acc__out0     <= sum_nxt;
      wsa_acc__out1     <= {16'd0, err_nxt};
      wsa_acc__out0_vld <= 1'b1;
      wsa_acc__out1_vld <= 1'b1;
    end else begin
      if (out0_take) begin
        wsa_acc__out0_vld <= 1'b0;
      end
      if (out1_take) begin
        wsa_acc__out1_vld <= 1'b0;
      end
    end
  end

  out0_hold_a: assert property (@(posedge clk) disable iff (rst)
    wsa_acc__out0_vld && !wsa_acc__out0_rdy |=> wsa_acc__out0_vld && $stable(wsa_acc__out0));
  out1_hold_a: assert property (@(posedge clk) disable iff (rst)
    wsa_acc__out1_vld && !wsa_acc__out1_rdy |=> wsa_acc__out1_vld && $stable(wsa_acc__out1));
  err_bound_a: assert property (@(posedge clk) disable iff (rst) err_reg <= beat_cnt);

endmodule

// File: tb/tb_wsa_acc.sv
// Bench for wsa_acc: window table with latency checks, back-pressure/skew/reset sequences,
// randomized windows against a window-sum model, and a COUNT=1 instance.
module tb_wsa_acc;
  localparam int COUNT = 4;

  typedef struct packed {
    logic [31:0] in0;
    logic [31:0] in1;
    logic [31:0] in2;
  } beat_t;

  typedef struct packed {
    beat_t [3:0] b;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst = 1'b1;

  logic [31:0] in_dat [3];
  logic [2:0]  in_vld;
  logic [2:0]  in_rdy;
  logic [31:0] o0_dat;
  logic [31:0] o1_dat;
  logic [1:0]  o_vld;
  logic [1:0]  o_rdy;

  logic [31:0] b_dat [3];
  logic [2:0]  b_vld;
  logic [2:0]  b_rdy;
  logic [31:0] b_o0;
  logic [31:0] b_o1;
  logic [1:0]  b_ov;
  logic [1:0]  b_ordy;

  wsa_acc #(.COUNT(COUNT)) dut (
    .clk(clk), .rst(rst),
    .wsa_acc__in0(in_dat[0]), .wsa_acc__in0_vld(in_vld[0]), .wsa_acc__in0_rdy(in_rdy[0]),
    .wsa_acc__in1(in_dat[1]), .wsa_acc__in1_vld(in_vld[1]), .wsa_acc__in1_rdy(in_rdy[1]),
    .wsa_acc__in2(in_dat[2]), .wsa_acc__in2_vld(in_vld[2]), .wsa_acc__in2_rdy(in_rdy[2]),
    .wsa_acc__out0(o0_dat), .wsa_acc__out0_vld(o_vld[0]), .wsa_acc__out0_rdy(o_rdy[0]),
    .wsa_acc__out1(o1_dat), .wsa_acc__out1_vld(o_vld[1]), .wsa_acc__out1_rdy(o_rdy[1])
  );

  wsa_acc #(.COUNT(1)) dut1 (
    .clk(clk), .rst(rst),
    .wsa_acc__in0(b_dat[0]), .wsa_acc__in0_vld(b_vld[0]), .wsa_acc__in0_rdy(b_rdy[0]),
    .wsa_acc__in1(b_dat[1]), .wsa_acc__in1_vld(b_vld[1]), .wsa_acc__in1_rdy(b_rdy[1]),
    .wsa_acc__in2(b_dat[2]), .wsa_acc__in2_vld(b_vld[2]), .wsa_acc__in2_rdy(b_rdy[2]),
    .wsa_acc__out0(b_o0), .wsa_acc__out0_vld(b_ov[0]), .wsa_acc__out0_rdy(b_ordy[0]),
    .wsa_acc__out1(b_o1), .wsa_acc__out1_vld(b_ov[1]), .wsa_acc__out1_rdy(b_ordy[1])
  );

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  beat_t       beat_q [$];
  int          lane_pos [3];
  int          xfer_cnt [3];
  logic [2:0]  lane_en = 3'b111;
  int          in_rate = 100;
  int          o_rate [2];
  logic [31:0] got0 [$];
  logic [31:0] got1 [$];
  int          last_xfer = 0;
  int          rise0 = -1;
  int          rise1 = -1;
  logic [1:0]  prev_ov = 2'b00;
  logic [1:0]  hold_vld = 2'b00;
  logic [31:0] hold_dat [2];

  function automatic beat_t mk(logic [31:0] a, logic [31:0] n, logic [31:0] x);
    beat_t r;
    r.in0 = a;
    r.in1 = n;
    r.in2 = x;
    return r;
  endfunction

  function automatic logic [31:0] lane_val(beat_t bt, int i);
    case (i)
      0:       return bt.in0;
      1:       return bt.in1;
      default: return bt.in2;
    endcase
  endfunction

  function automatic bit is_bad(beat_t bt);
    return ((bt.in1 & bt.in2) != 32'd0) || ((bt.in1 | bt.in2) != bt.in0);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 3; i++) begin
      if (lane_en[i] && lane_pos[i] < beat_q.size() && int'($urandom_range(99)) < in_rate) begin
        in_vld[i] = 1'b1;
        in_dat[i] = lane_val(beat_q[lane_pos[i]], i);
      end else begin
        in_vld[i] = 1'b0;
        in_dat[i] = $urandom;
      end
    end
    for (int k = 0; k < 2; k++) o_rdy[k] = (int'($urandom_range(99)) < o_rate[k]);
  endtask

  // One clock: sample at negedge, advance at posedge, re-drive 1 time unit later.
  task automatic step();
    logic [2:0]  fire;
    logic [1:0]  take;
    logic [31:0] od [2];
    @(negedge clk);
    fire  = in_vld & in_rdy;
    take  = o_vld & o_rdy;
    od[0] = o0_dat;
    od[1] = o1_dat;
    for (int k = 0; k < 2; k++) begin
      if (hold_vld[k]) begin
        check($sformatf("out%0d_vld_held", k), 32'(o_vld[k]), 32'd1);
        check($sformatf("out%0d_stable", k), od[k], hold_dat[k]);
      end
      hold_vld[k] = o_vld[k] & ~o_rdy[k];
      hold_dat[k] = od[k];
    end
    if (o_vld[0] && !prev_ov[0]) rise0 = cyc;
    if (o_vld[1] && !prev_ov[1]) rise1 = cyc;
    prev_ov = o_vld;
    if (take[0]) got0.push_back(o0_dat);
    if (take[1]) got1.push_back(o1_dat);
    for (int i = 0; i < 3; i++) begin
      if (fire[i]) begin
        lane_pos[i]++;
        xfer_cnt[i]++;
        last_xfer = cyc + 1;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    drive();
  endtask

  task automatic run_until(int n, int budget, string name);
    int c = 0;
    while ((got0.size() < n || got1.size() < n) && c < budget) begin
      step();
      c++;
    end
    check($sformatf("%s_outputs_seen", name), 32'((got0.size() >= n) && (got1.size() >= n)), 32'd1);
  endtask

  task automatic do_reset(int n, bit chk);
    rst = 1'b1;
    if (chk) begin
      in_vld = 3'b111;
      b_vld  = 3'b111;
    end
    repeat (n) begin
      @(posedge clk);
      #1;
      if (chk) begin
        check("rst_rdy", 32'({b_rdy, in_rdy}), 32'd0);
        check("rst_out_vld", 32'({b_ov, o_vld}), 32'd0);
        check("rst_out0", o0_dat, 32'd0);
        check("rst_out1", o1_dat, 32'd0);
      end
    end
    rst = 1'b0;
    b_vld = 3'b000;
    beat_q.delete();
    got0.delete();
    got1.delete();
    for (int i = 0; i < 3; i++) begin
      lane_pos[i] = 0;
      xfer_cnt[i] = 0;
    end
    hold_vld = 2'b00;
    prev_ov  = 2'b00;
    drive();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    vec_t        vecs [6];
    beat_t       clean;
    beat_t       bt;
    beat_t       bb [3];
    logic [31:0] exp0 [$];
    logic [31:0] exp1 [$];
    logic [31:0] s;
    logic [31:0] e;
    logic [31:0] p;
    logic [31:0] q;
    int          c;
    int          r;

    clean = mk(32'hFFF0FFF0, 32'h00F000F0, 32'hFF00FF00);
    for (int j = 0; j < 4; j++) vecs[0].b[j] = clean;
    vecs[0].e0 = 32'hFFC3FFC0; vecs[0].e1 = 32'd0;
    // three beats of 0xFFF0FFF0 plus one zero OR word
    vecs[1] = vecs[0];
    vecs[1].b[2].in0 = 32'd0;
    vecs[1].e0 = 32'hFFD2FFD0; vecs[1].e1 = 32'd1;
    for (int j = 0; j < 4; j++) vecs[2].b[j] = mk(32'd0, 32'd0, 32'd0);
    vecs[2].e0 = 32'd0; vecs[2].e1 = 32'd0;
    for (int j = 0; j < 4; j++) vecs[3].b[j] = mk(32'd1, 32'd1, 32'd1);
    vecs[3].e0 = 32'd4; vecs[3].e1 = 32'd4;
    vecs[4].b[0] = mk(32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF);
    vecs[4].b[1] = mk(32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFF0000);
    vecs[4].b[2] = mk(32'h3, 32'h1, 32'h1);
    vecs[4].b[3] = mk(32'h2, 32'h0, 32'h1);
    vecs[4].e0 = 32'h00000003; vecs[4].e1 = 32'd2;
    vecs[5].b[0] = mk(32'hF, 32'h5, 32'hF);
    vecs[5].b[1] = mk(32'hF, 32'h5, 32'hA);
    vecs[5].b[2] = mk(32'hE, 32'h5, 32'hA);
    vecs[5].b[3] = mk(32'h0, 32'h0, 32'h0);
    vecs[5].e0 = 32'h2C; vecs[5].e1 = 32'd2;

    o_rate[0] = 100;
    o_rate[1] = 100;
    b_ordy = 2'b11;
    for (int i = 0; i < 3; i++) begin
      in_dat[i] = 32'd0;
      b_dat[i]  = 32'd0;
    end
    do_reset(3, 1'b1);

    for (int v = 0; v < 6; v++) begin
      got0.delete();
      got1.delete();
      rise0 = -1;
      rise1 = -1;
      for (int j = 0; j < 4; j++) beat_q.push_back(vecs[v].b[j]);
      run_until(1, 60, $sformatf("vec%0d", v));
      repeat (2) step();
      check($sformatf("vec%0d_out0", v), (got0.size() > 0) ? got0[0] : 32'hxxxxxxxx, vecs[v].e0);
      check($sformatf("vec%0d_out1", v), (got1.size() > 0) ? got1[0] : 32'hxxxxxxxx, vecs[v].e1);
      check($sformatf("vec%0d_lat0", v), 32'(rise0), 32'(last_xfer + 1));
      check($sformatf("vec%0d_lat1", v), 32'(rise1), 32'(last_xfer + 1));
      check($sformatf("vec%0d_count", v), 32'(got0.size() + got1.size()), 32'd2);
    end

    // out1 held off after a window closes, with a second window queued behind it
    got0.delete();
    got1.delete();
    o_rate[1] = 0;
    for (int j = 0; j < 8; j++) beat_q.push_back(clean);
    c = 0;
    while (!o_vld[1] && c < 60) begin
      step();
      c++;
    end
    check("bp_emit", 32'(o_vld[1]), 32'd1);
    for (int i = 0; i < 3; i++) xfer_cnt[i] = 0;
    step();
    check("bp_out0_drop", 32'(o_vld[0]), 32'd0);
    repeat (9) step();
    check("bp_out1_held", 32'(o_vld[1]), 32'd1);
    for (int i = 0; i < 3; i++) check($sformatf("bp_in%0d_at_most_one", i), 32'(xfer_cnt[i] <= 1), 32'd1);
    check("bp_stall_rdy", 32'(in_rdy), 32'd0);
    o_rate[1] = 100;
    run_until(2, 80, "bp");
    repeat (2) step();
    for (int w = 0; w < 2; w++) begin
      check($sformatf("bp_w%0d_out0", w), (got0.size() > w) ? got0[w] : 32'hxxxxxxxx, 32'hFFC3FFC0);
      check($sformatf("bp_w%0d_out1", w), (got1.size() > w) ? got1[w] : 32'hxxxxxxxx, 32'd0);
    end

    // in1 arrives late: in0/in2 hold one beat each and stall
    got0.delete();
    got1.delete();
    lane_en = 3'b101;
    for (int i = 0; i < 3; i++) xfer_cnt[i] = 0;
    for (int j = 0; j < 4; j++) beat_q.push_back(clean);
    repeat (6) step();
    check("skew_in0_xfers", 32'(xfer_cnt[0]), 32'd1);
    check("skew_in2_xfers", 32'(xfer_cnt[2]), 32'd1);
    check("skew_in1_xfers", 32'(xfer_cnt[1]), 32'd0);
    check("skew_rdy_low", 32'({in_rdy[2], in_rdy[0]}), 32'd0);
    check("skew_no_output", 32'(o_vld), 32'd0);
    lane_en = 3'b111;
    run_until(1, 60, "skew");
    repeat (2) step();
    check("skew_out0", (got0.size() > 0) ? got0[0] : 32'hxxxxxxxx, 32'hFFC3FFC0);
    check("skew_out1", (got1.size() > 0) ? got1[0] : 32'hxxxxxxxx, 32'd0);

    // reset after two mismatching beats are absorbed into the window
    got0.delete();
    got1.delete();
    for (int i = 0; i < 3; i++) xfer_cnt[i] = 0;
    for (int j = 0; j < 4; j++) beat_q.push_back(mk(32'd1, 32'd1, 32'd1));
    c = 0;
    while ((xfer_cnt[0] < 3 || xfer_cnt[1] < 3 || xfer_cnt[2] < 3) && c < 50) begin
      step();
      c++;
    end
    do_reset(1, 1'b0);
    check("mid_rst_out_vld", 32'(o_vld), 32'd0);
    for (int j = 0; j < 4; j++) beat_q.push_back(clean);
    run_until(1, 60, "mid_rst");
    repeat (4) step();
    check("mid_rst_out0", (got0.size() > 0) ? got0[0] : 32'hxxxxxxxx, 32'hFFC3FFC0);
    check("mid_rst_out1", (got1.size() > 0) ? got1[0] : 32'hxxxxxxxx, 32'd0);
    check("mid_rst_count", 32'(got0.size()), 32'd1);

    // randomized windows with throttled inputs and outputs
    got0.delete();
    got1.delete();
    in_rate = 70;
    o_rate[0] = 60;
    o_rate[1] = 60;
    for (int w = 0; w < 20; w++) begin
      s = 32'd0;
      e = 32'd0;
      for (int j = 0; j < 4; j++) begin
        p = $urandom;
        q = $urandom;
        r = int'($urandom_range(9));
        if (r < 6) bt = mk(p | q, p & q, p ^ q);
        else if (r < 8) bt = mk((p | q) ^ (32'd1 << $urandom_range(31)), p & q, p ^ q);
        else bt = mk($urandom, $urandom, $urandom);
        beat_q.push_back(bt);
        s = s + bt.in0;
        e = e + 32'(is_bad(bt));
      end
      exp0.push_back(s);
      exp1.push_back(e);
    end
    run_until(20, 4000, "rand");
    repeat (5) step();
    check("rand_out0_count", 32'(got0.size()), 32'd20);
    check("rand_out1_count", 32'(got1.size()), 32'd20);
    for (int w = 0; w < 20; w++) begin
      check($sformatf("rand_w%0d_out0", w), (got0.size() > w) ? got0[w] : 32'hxxxxxxxx, exp0[w]);
      check($sformatf("rand_w%0d_out1", w), (got1.size() > w) ? got1[w] : 32'hxxxxxxxx, exp1[w]);
    end

    // COUNT=1: every beat closes a window
    p = $urandom;
    q = $urandom;
    bb[0] = clean;
    bb[1] = mk(32'd1, 32'd1, 32'd1);
    bb[2] = mk(p | q, p & q, p ^ q);
    for (int k = 0; k < 3; k++) begin
      b_vld = 3'b111;
      for (int i = 0; i < 3; i++) b_dat[i] = lane_val(bb[k], i);
      c = 0;
      @(negedge clk);
      while (b_rdy != 3'b111 && c < 10) begin
        @(negedge clk);
        c++;
      end
      @(posedge clk);
      #1;
      b_vld = 3'b000;
      c = 0;
      @(negedge clk);
      while (b_ov != 2'b11 && c < 10) begin
        @(negedge clk);
        c++;
      end
      check($sformatf("c1_b%0d_vld", k), 32'(b_ov), 32'd3);
      check($sformatf("c1_b%0d_out0", k), b_o0, bb[k].in0);
      check($sformatf("c1_b%0d_out1", k), b_o1, 32'(is_bad(bb[k])));
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
